// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, rgb332 type and box palette
package vga_pkg;
  localparam int HBP     = 144;
  localparam int VBP     = 31;
  localparam int HACT    = 640;
  localparam int VACT    = 480;
  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;
  localparam int BOX     = 32;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  localparam rgb332_t BG_RGB = 8'h00;
  localparam rgb332_t PALETTE [0:7] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h92};
endpackage

// File: rtl/vga_bounce_axis.sv
// vga_bounce_axis: one-axis box position/direction update with edge clamp and hit flag
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int EXT = 640
) (
  input  logic       dclk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] speed_i,
  output logic [9:0] pos_o,
  output logic       hit_o
);
  localparam int LIM = EXT - BOX;
  localparam logic signed [11:0] LIM_S = 12'(LIM);
  logic [9:0] pos_q, pos_d;
  logic dir_q, dir_d, hi, lo;
  logic signed [11:0] nx;
  // candidate position in signed space so undershoot below 0 is visible
  always_comb begin
    nx = dir_q ? $signed({2'b0, pos_q}) + $signed({9'b0, speed_i})
               : $signed({2'b0, pos_q}) - $signed({9'b0, speed_i});
    hi = nx > LIM_S;
    lo = nx < 12'sd0;
    pos_d = !en_i ? pos_q : hi ? 10'(LIM) : lo ? 10'd0 : nx[9:0];
    dir_d = !en_i ? dir_q : hi ? 1'b0 : lo ? 1'b1 : dir_q;
    hit_o = en_i & (hi | lo);
  end
  // state moves only on enabled frame ticks; reset centres the box heading positive
  always_ff @(posedge dclk_i) begin
    if (!clr_i) begin
      pos_q <= 10'(LIM / 2);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end
  assign pos_o = pos_q;
endmodule

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: draws a bouncing palette-cycling box as registered 3:3:2 RGB
module vga_bounce_renderer
  import vga_pkg::*;
(
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic [2:0] speed,
  input  logic       pause,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [7:0] bounce_cnt
);
  logic tick, en, hx, hy, active, in_box;
  logic [10:0] x, y;
  logic [2:0] ci_q, ci_d;
  logic [7:0] cnt_q, cnt_d;
  rgb332_t rgb_q, rgb_d;
  vga_bounce_axis #(.EXT(HACT)) u_x (
    .dclk_i(dclk), .clr_i(clr), .en_i(en), .speed_i(speed), .pos_o(box_x), .hit_o(hx)
  );
  vga_bounce_axis #(.EXT(VACT)) u_y (
    .dclk_i(dclk), .clr_i(clr), .en_i(en), .speed_i(speed), .pos_o(box_y), .hit_o(hy)
  );
  // frame tick gating, pixel classification and bounce bookkeeping
  always_comb begin
    tick = hc == 10'(HPIXELS - 1) && vc == 10'(VLINES - 1);
    en = tick & ~pause & |speed;
    active = hc >= 10'(HBP) && hc < 10'(HBP + HACT) && vc >= 10'(VBP) && vc < 10'(VBP + VACT);
    x = {1'b0, hc} - 11'(HBP);
    y = {1'b0, vc} - 11'(VBP);
    in_box = x >= {1'b0, box_x} && x < {1'b0, box_x} + 11'(BOX)
          && y >= {1'b0, box_y} && y < {1'b0, box_y} + 11'(BOX);
    rgb_d = !active ? rgb332_t'(8'h00) : in_box ? PALETTE[ci_q] : BG_RGB;
    ci_d = (hx | hy) ? ci_q + 3'd1 : ci_q;
    cnt_d = (hx | hy) ? cnt_q + 8'd1 : cnt_q;
  end
  // registered pixel output and colour/count advance, one step per bounce tick
  always_ff @(posedge dclk) begin
    if (!clr) begin
      rgb_q <= '0;
      ci_q  <= '0;
      cnt_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      ci_q  <= ci_d;
      cnt_q <= cnt_d;
    end
  end
  assign red = rgb_q.r;
  assign green = rgb_q.g;
  assign blue = rgb_q.b;
  assign bounce_cnt = cnt_q;
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb_vga_bounce_renderer: randomized checks of vga_bounce_renderer against a behavioural model
module tb_vga_bounce_renderer;
  logic dclk = 1'b0;
  logic clr = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic [2:0] speed = '0;
  logic pause = 1'b0;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [9:0] box_x, box_y;
  logic [7:0] bounce_cnt;
  int total = 0, bad = 0;
  int mx, my, mdx, mdy, mci, mcnt;
  logic [7:0] pal [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h92};

  vga_bounce_renderer dut (
    .dclk(dclk), .clr(clr), .hc(hc), .vc(vc), .speed(speed), .pause(pause),
    .red(red), .green(green), .blue(blue), .box_x(box_x), .box_y(box_y), .bounce_cnt(bounce_cnt)
  );

  always #5 dclk = ~dclk;

  function automatic logic [7:0] exp_rgb(int h, int v);
    int x, y;
    if (h < 144 || h >= 784 || v < 31 || v >= 511) return 8'h00;
    x = h - 144;
    y = v - 31;
    if (x >= mx && x < mx + 32 && y >= my && y < my + 32) return pal[mci];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rgb();
    return {red, green, blue};
  endfunction

  task automatic model_reset();
    mx = 304; my = 224; mdx = 1; mdy = 1; mci = 0; mcnt = 0;
  endtask

  task automatic model_tick(int sp, int pz);
    int nx, ny;
    bit hit;
    if (pz != 0 || sp == 0) return;
    hit = 0;
    nx = mx + mdx * sp;
    ny = my + mdy * sp;
    if (nx > 608) begin mx = 608; mdx = -1; hit = 1; end
    else if (nx < 0) begin mx = 0; mdx = 1; hit = 1; end
    else mx = nx;
    if (ny > 448) begin my = 448; mdy = -1; hit = 1; end
    else if (ny < 0) begin my = 0; mdy = 1; hit = 1; end
    else my = ny;
    if (hit) begin mci = (mci + 1) % 8; mcnt = (mcnt + 1) % 256; end
  endtask

  task automatic drive(int h, int v);
    hc = 10'(h);
    vc = 10'(v);
    @(posedge dclk);
    @(negedge dclk);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(448, 255);
    drive(448, 255);
    model_reset();
    total++;
    if ({box_x, box_y, bounce_cnt, rgb()} !== {10'd304, 10'd224, 8'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: got x=%0d y=%0d cnt=%0d rgb=%h want 304 224 0 00", box_x, box_y, bounce_cnt, rgb());
    end
    clr = 1'b1;
    drive(448, 255);
    total++;
    if ({box_x, box_y, bounce_cnt, rgb()} !== {10'd304, 10'd224, 8'd0, 8'hFF}) begin
      bad++;
      $display("FAIL reset_first_pixel: got x=%0d y=%0d cnt=%0d rgb=%h want 304 224 0 ff", box_x, box_y, bounce_cnt, rgb());
    end
  endtask

  task automatic test_latency();
    drive(100, 255);
    total++;
    if (rgb() !== 8'h00) begin bad++; $display("FAIL blank_hbp: got %h want 00", rgb()); end
    drive(144, 255);
    total++;
    if (rgb() !== 8'h00) begin bad++; $display("FAIL bg_first_col: got %h want 00", rgb()); end
    drive(448, 255);
    hc = 10'd100;
    #1;
    total++;
    if (rgb() !== 8'hFF) begin bad++; $display("FAIL latency_hold: got %h want ff", rgb()); end
    @(posedge dclk);
    @(negedge dclk);
    total++;
    if (rgb() !== 8'h00) begin bad++; $display("FAIL latency_next: got %h want 00", rgb()); end
  endtask

  task automatic test_motion();
    speed = 3'd4;
    pause = 1'b0;
    drive(799, 520);
    model_tick(4, 0);
    total++;
    if ({box_x, box_y, bounce_cnt} !== {10'd308, 10'd228, 8'd0}) begin
      bad++;
      $display("FAIL motion_tick: got x=%0d y=%0d cnt=%0d want 308 228 0", box_x, box_y, bounce_cnt);
    end
    drive(144 + 307, 31 + 228);
    total++;
    if (rgb() !== 8'h00) begin bad++; $display("FAIL motion_left_bg: got %h want 00", rgb()); end
    drive(144 + 308, 31 + 228);
    total++;
    if (rgb() !== 8'hFF) begin bad++; $display("FAIL motion_left_box: got %h want ff", rgb()); end
  endtask

  task automatic test_random();
    int h, v, sp, pz;
    for (int i = 0; i < 1500; i++) begin
      sp = $urandom_range(0, 7);
      pz = ($urandom_range(0, 3) == 0) ? 1 : 0;
      speed = 3'(sp);
      pause = 1'(pz);
      if ($urandom_range(0, 1) == 0) begin
        drive(799, 520);
        model_tick(sp, pz);
        total++;
        if ({box_x, box_y, bounce_cnt} !== {10'(mx), 10'(my), 8'(mcnt)}) begin
          bad++;
          $display("FAIL rand_tick: got x=%0d y=%0d cnt=%0d want %0d %0d %0d", box_x, box_y, bounce_cnt, mx, my, mcnt);
        end
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 1023);
        end else begin
          h = 144 + mx + $urandom_range(0, 37) - 3;
          v = 31 + my + $urandom_range(0, 37) - 3;
        end
        if (h == 799 && v == 520) h = 798;
        drive(h, v);
        total++;
        if (rgb() !== exp_rgb(h, v)) begin
          bad++;
          $display("FAIL rand_pixel hc=%0d vc=%0d: got %h want %h", h, v, rgb(), exp_rgb(h, v));
        end
      end
    end
  endtask

  task automatic test_pause_reset();
    pause = 1'b1;
    speed = 3'd5;
    for (int i = 0; i < 3; i++) begin
      drive(799, 520);
      total++;
      if ({box_x, box_y, bounce_cnt} !== {10'(mx), 10'(my), 8'(mcnt)}) begin
        bad++;
        $display("FAIL pause_hold: got x=%0d y=%0d cnt=%0d want %0d %0d %0d", box_x, box_y, bounce_cnt, mx, my, mcnt);
      end
    end
    clr = 1'b0;
    drive(400, 200);
    model_reset();
    clr = 1'b1;
    total++;
    if ({box_x, box_y, bounce_cnt, rgb()} !== {10'd304, 10'd224, 8'd0, 8'h00}) begin
      bad++;
      $display("FAIL midframe_reset: got x=%0d y=%0d cnt=%0d rgb=%h want 304 224 0 00", box_x, box_y, bounce_cnt, rgb());
    end
    pause = 1'b0;
    drive(448, 255);
    total++;
    if (rgb() !== 8'hFF) begin bad++; $display("FAIL post_reset_colour: got %h want ff", rgb()); end
  endtask

  initial begin
    @(negedge dclk);
    test_reset();
    test_latency();
    test_motion();
    test_random();
    test_pause_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
